dac_update_arbiter: RTL
=======================

// Module: dac_update_arbiter
// PURPOSE
//  Shares the 4-channel RGB DAC writer (dac_write) between two requesters (A: host regs, B: fade engine).
//  Round-robin grants a requester, latches its 4x8-bit channel set, issues one start to the writer, and
//  acks the requester when the writer returns to ready. Also sequences power, clear, and periodic refresh.
// PARAMETERS
//  REFRESH_CYCLES  100000  idle cycles while powered before last channel set is rewritten (0 = off)
//  GUARD_CYCLES    4       hold-off after power-up, power-down or clear before next start
//  BUSY_TIMEOUT    64      cycles allowed in WAIT_BUSY / WAIT_DONE before err is set
// PORTS
//  clk          in   1   system clock (<=50 MHz, same clock as dac_write)
//  resetn       in   1   asynchronous active-low reset
//  pwr_en       in   1   level: DAC powered when high
//  clear_req    in   1   one-cycle pulse: request DAC clear
//  req_a/req_b  in   1   level request, held until ack
//  ch_a/ch_b    in   32  {ch3,ch2,ch1,ch0}, 8 bits each; must be stable while req high
//  nch_a/nch_b  in   2   channels-1 to write (3 = all four)
//  ack_a/ack_b  out  1   one-cycle pulse: update completed on DAC
//  dac_ready    in   1   ready from writer
//  dac_start    out  1   one-cycle start pulse to writer
//  dac_pwr      out  1   pwr to writer
//  dac_clear    out  1   one-cycle clear pulse to writer
//  dac_ch0..3   out  8   latched channel values (held stable between starts)
//  dac_nch      out  2   num_of_channels to writer
//  busy         out  1   high in any state other than IDLE
//  err          out  1   sticky: writer handshake timeout; cleared only by reset
// BEHAVIOUR
//  Reset (async, resetn=0): all outputs 0, state=GUARD with guard counter loaded to GUARD_CYCLES,
//   rr pointer=A, refresh counter=0, last-set valid=0.
//  dac_pwr is registered pwr_en (1-cycle delay). Any pwr_en edge forces state GUARD (counter reloaded),
//   aborting pending wait; an in-flight requester is NOT acked and is regranted later.
//  States: IDLE, START, WAIT_BUSY, WAIT_DONE, GUARD.
//  GUARD: count down; at 0 -> IDLE. No starts/clears issued in GUARD.
//  IDLE (dac_pwr=1 and dac_ready=1 required, else stay): priority per cycle:
//   1 clear pending -> dac_clear=1 for 1 cycle, clear pending dropped, -> GUARD.
//   2 req_a/req_b -> round robin: if both, grant != last granted; latch ch/nch into dac_ch*/dac_nch,
//     record grant, -> START.
//   3 refresh counter == REFRESH_CYCLES and last-set valid -> reissue latched set, no ack, -> START.
//  clear_req pulses are captured into a pending flag in any state (multiple collapse to one);
//   clear_req with dac_pwr=0 is discarded.
//  START: dac_start=1 exactly one cycle -> WAIT_BUSY.
//  WAIT_BUSY: wait dac_ready=0 -> WAIT_DONE.
//  WAIT_DONE: wait dac_ready=1 -> pulse ack of granted requester (none for refresh), set last-set
//   valid, refresh counter=0, -> IDLE. Latency req->ack with idle writer = 2 + writer time.
//  Timeout: BUSY_TIMEOUT cycles in WAIT_BUSY/WAIT_DONE combined -> err=1, no ack, -> GUARD.
//  Refresh counter: increments in IDLE when powered, saturates at REFRESH_CYCLES; cleared on any
//   completed write and on pwr_en edges. Requests/clear always beat refresh on same cycle.
//  Requests with dac_pwr=0 wait (no ack) until power-up + guard.
//  dac_ch*/dac_nch change only on grant; never during START..WAIT_DONE.
// TESTING
//  pwr_en=1, req_a with ch_a=0x40302010,nch=3 -> after guard one dac_start, dac_ch0=0x10..ch3=0x40, one ack_a.
//  req_a and req_b both high, last grant A -> B served first, then A; each acked exactly once.
//  clear_req same cycle as req_a in IDLE -> dac_clear first, GUARD_CYCLES hold-off, then A served.
//  writer model holds dac_ready=1 after start -> err=1 after 64 cycles, no ack, returns via GUARD.
//  REFRESH_CYCLES=20, one write then idle -> dac_start repeats every write+20 idle cycles, no ack pulses.
//  resetn low during WAIT_DONE -> all outputs 0 immediately; request regranted after guard.

Source files
------------

// File: rtl/dac_update_arbiter.sv
// Two-requester round-robin front end for the shared RGB DAC writer.
// Sequences power guard, clear pulses, periodic refresh and handshake timeout.
`timescale 1ns/1ps
module dac_update_arbiter #(
    parameter int REFRESH_CYCLES = 100000,
    parameter int GUARD_CYCLES   = 4,
    parameter int BUSY_TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pwr_en,
    input  logic        clear_req,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [31:0] ch_a,
    input  logic [31:0] ch_b,
    input  logic [1:0]  nch_a,
    input  logic [1:0]  nch_b,
    output logic        ack_a,
    output logic        ack_b,
    input  logic        dac_ready,
    output logic        dac_start,
    output logic        dac_pwr,
    output logic        dac_clear,
    output logic [7:0]  dac_ch0,
    output logic [7:0]  dac_ch1,
    output logic [7:0]  dac_ch2,
    output logic [7:0]  dac_ch3,
    output logic [1:0]  dac_nch,
    output logic        busy,
    output logic        err
);
    localparam int GW = $clog2(GUARD_CYCLES + 2);
    localparam int RW = $clog2(REFRESH_CYCLES + 2);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [GW-1:0] GLOAD = GW'(GUARD_CYCLES);
    localparam logic [RW-1:0] RLOAD = RW'(REFRESH_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GUARD} state_t;

    typedef struct packed {
        logic [31:0] ch;
        logic [1:0]  nch;
    } chset_t;

    state_t        state;
    logic [GW-1:0] gcnt;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] rcnt;
    logic          clr_pend;
    logic          last_b;
    logic          gnt_a;
    logic          gnt_b;
    logic          set_vld;

    logic   pwr_edge;
    logic   clr_now;
    logic   pick_b;
    logic   refresh_due;
    chset_t sel;

    assign pwr_edge    = pwr_en ^ dac_pwr;
    // A clear arriving on the same cycle as a request must still win.
    assign clr_now     = clr_pend | (clear_req & dac_pwr);
    assign pick_b      = req_b & (~req_a | ~last_b);
    assign refresh_due = (REFRESH_CYCLES != 0) && (rcnt == RLOAD) && set_vld;
    assign sel         = pick_b ? {ch_b, nch_b} : {ch_a, nch_a};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= GUARD;
            gcnt      <= GLOAD;
            tcnt      <= '0;
            rcnt      <= '0;
            clr_pend  <= 1'b0;
            last_b    <= 1'b0;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            set_vld   <= 1'b0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            dac_start <= 1'b0;
            dac_pwr   <= 1'b0;
            dac_clear <= 1'b0;
            dac_ch0   <= '0;
            dac_ch1   <= '0;
            dac_ch2   <= '0;
            dac_ch3   <= '0;
            dac_nch   <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            dac_pwr   <= pwr_en;
            dac_start <= 1'b0;
            dac_clear <= 1'b0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            if (clear_req && dac_pwr)
                clr_pend <= 1'b1;

            if (pwr_edge) begin
                state <= GUARD;
                gcnt  <= GLOAD;
                rcnt  <= '0;
                busy  <= 1'b1;
            end else begin
                case (state)
                    GUARD: begin
                        if (gcnt == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gcnt <= gcnt - 1'b1;
                        end
                    end
                    IDLE: begin
                        if (dac_pwr && rcnt != RLOAD)
                            rcnt <= rcnt + 1'b1;
                        if (dac_pwr && dac_ready) begin
                            if (clr_now) begin
                                dac_clear <= 1'b1;
                                clr_pend  <= 1'b0;
                                state     <= GUARD;
                                gcnt      <= GLOAD;
                                busy      <= 1'b1;
                            end else if (req_a || req_b) begin
                                {dac_ch3, dac_ch2, dac_ch1, dac_ch0} <= sel.ch;
                                dac_nch   <= sel.nch;
                                gnt_a     <= ~pick_b;
                                gnt_b     <= pick_b;
                                last_b    <= pick_b;
                                dac_start <= 1'b1;
                                state     <= START;
                                busy      <= 1'b1;
                            end else if (refresh_due) begin
                                // Refresh replays the latched set and owes nobody an ack.
                                gnt_a     <= 1'b0;
                                gnt_b     <= 1'b0;
                                dac_start <= 1'b1;
                                state     <= START;
                                busy      <= 1'b1;
                            end
                        end
                    end
                    START: begin
                        tcnt  <= '0;
                        state <= WAIT_BUSY;
                    end
                    WAIT_BUSY: begin
                        if (tcnt == TLAST) begin
                            err   <= 1'b1;
                            state <= GUARD;
                            gcnt  <= GLOAD;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                            if (!dac_ready)
                                state <= WAIT_DONE;
                        end
                    end
                    WAIT_DONE: begin
                        if (dac_ready) begin
                            ack_a   <= gnt_a;
                            ack_b   <= gnt_b;
                            set_vld <= 1'b1;
                            rcnt    <= '0;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end else if (tcnt == TLAST) begin
                            err   <= 1'b1;
                            state <= GUARD;
                            gcnt  <= GLOAD;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= GUARD;
                        gcnt  <= GLOAD;
                        busy  <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule
